// File: rtl/mips_irom_pkg.sv
// Shared types and helpers for the programmable MIPS instruction ROM.
package mips_irom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } irom_state_t;

  localparam logic [31:0] IROM_DEFAULT_BASE = 32'hBFC00000;
  localparam logic [31:0] MIPS_NOP          = 32'h0;

  function automatic logic [31:0] byteswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/mips_instr_rom_ws_if.sv
// CPU instruction-fetch bus with waitrequest handshake.
interface mips_instr_rom_ws_if;
  logic [31:0] instr_address;
  logic        instr_read;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;

  modport master (
    output instr_address,
    output instr_read,
    input  instr_readdata,
    input  instr_waitrequest
  );

  modport slave (
    input  instr_address,
    input  instr_read,
    output instr_readdata,
    output instr_waitrequest
  );
endinterface

// File: rtl/mips_irom_wait_ctr.sv
// Wait-state counter: loads WAIT_STATES on start/abort, counts down, flags the last wait cycle.
module mips_irom_wait_ctr
  import mips_irom_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = 4'(WAIT_STATES);
    end else if (dec_i) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clk_enable) begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == 4'd1);

endmodule

// File: rtl/mips_instr_rom_ws.sv
// Programmable instruction ROM with wait states, byte-lane swap and sticky fault flag.
// Optional macro MIPS_IROM_FETCH_COUNT_EN adds fetch_count and fault_addr outputs.
module mips_instr_rom_ws
  import mips_irom_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = IROM_DEFAULT_BASE,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  mips_instr_rom_ws_if.slave       instr,
  output logic                     instr_fault,
  input  logic                     prog_write,
  input  logic [$clog2(DEPTH)-1:0] prog_index,
  input  logic [31:0]              prog_data
`ifdef MIPS_IROM_FETCH_COUNT_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [31:0]              fault_addr
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

  irom_state_t   state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   rdata_q;
  logic          fault_q;
  logic          ctr_load, ctr_dec, ctr_last;
  logic          load_out;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   fetch_addr, offset, raw_word, fetch_data;
  logic [AW-1:0] idx;
  logic          in_window, bad_addr;

  mips_irom_wait_ctr #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_ctr (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .load_i     (ctr_load),
    .dec_i      (ctr_dec),
    .last_o     (ctr_last)
  );

  always_ff @(posedge clk) begin
    if (clk_enable && prog_write) begin
      mem[prog_index] <= prog_data;
    end
  end

  // With no wait states the load happens in IDLE, before addr_q has captured the request.
  assign fetch_addr = (state_q == IDLE) ? instr.instr_address : addr_q;
  assign offset     = fetch_addr - BASE_ADDR;
  assign in_window  = (offset < WIN_BYTES) && (fetch_addr[1:0] == 2'b00);
  assign idx        = offset[AW+1:2];
  assign bad_addr   = !in_window && (fetch_addr != 32'h0);

  always_comb begin
    raw_word = mem[idx];
    if (prog_write && (prog_index == idx)) begin
      raw_word = prog_data;
    end
    fetch_data = MIPS_NOP;
    if (in_window) begin
      fetch_data = BIG_ENDIAN ? byteswap32(raw_word) : raw_word;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    load_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instr.instr_read) begin
          addr_d   = instr.instr_address;
          ctr_load = 1'b1;
          if (WAIT_STATES == 0) begin
            load_out = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (!instr.instr_read) begin
          ctr_load = 1'b1;
          state_d  = IDLE;
        end else if (instr.instr_address != addr_q) begin
          ctr_load = 1'b1;
          addr_d   = instr.instr_address;
        end else if (ctr_last) begin
          load_out = 1'b1;
          state_d  = DONE;
        end else begin
          ctr_dec  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else if (clk_enable) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else if (clk_enable) begin
      addr_q <= addr_d;
      if (load_out) begin
        rdata_q <= fetch_data;
        if (bad_addr) begin
          fault_q <= 1'b1;
        end
      end
    end
  end

`ifdef MIPS_IROM_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fault_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= '0;
      fault_addr_q  <= '0;
    end else if (clk_enable) begin
      if ((state_q == DONE) && (fetch_count_q != '1)) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (load_out && bad_addr && !fault_q) begin
        fault_addr_q <= fetch_addr;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign fault_addr  = fault_addr_q;
`endif

  // Reset gating keeps waitrequest low while reset is held, even with a request pending.
  assign instr.instr_waitrequest = reset && instr.instr_read && (state_q != DONE);
  assign instr.instr_readdata    = rdata_q;
  assign instr_fault             = fault_q;

endmodule

// File: tb/tb_mips_instr_rom_ws.sv
// Bench for mips_instr_rom_ws: three instances (0, 2, 3 wait states) against an address-rule model.
module tb_mips_instr_rom_ws;

  localparam longint unsigned BASE  = 64'hBFC00000;
  localparam int unsigned     DEPTH = 64;
  localparam logic [31:0]     B32   = 32'hBFC00000;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        prog_write;
  logic [5:0]  prog_index;
  logic [31:0] prog_data;

  logic [31:0] addr_drv [3];
  logic        rd       [3];
  logic [31:0] rdata    [3];
  logic        wreq     [3];
  logic        flt      [3];

  logic [31:0] mem_m [DEPTH];
  logic [2:0]  flt_m;

  int checks = 0;
  int errors = 0;

  mips_instr_rom_ws_if bus0 ();
  mips_instr_rom_ws_if bus1 ();
  mips_instr_rom_ws_if bus2 ();

`ifdef MIPS_IROM_FETCH_COUNT_EN
  logic [31:0] fc0, fc1, fc2, fa0, fa1, fa2;
`endif

  assign bus0.instr_address = addr_drv[0];
  assign bus1.instr_address = addr_drv[1];
  assign bus2.instr_address = addr_drv[2];
  assign bus0.instr_read    = rd[0];
  assign bus1.instr_read    = rd[1];
  assign bus2.instr_read    = rd[2];
  assign rdata[0] = bus0.instr_readdata;
  assign rdata[1] = bus1.instr_readdata;
  assign rdata[2] = bus2.instr_readdata;
  assign wreq[0]  = bus0.instr_waitrequest;
  assign wreq[1]  = bus1.instr_waitrequest;
  assign wreq[2]  = bus2.instr_waitrequest;

  mips_instr_rom_ws #(.DEPTH(64), .BASE_ADDR(32'hBFC00000), .WAIT_STATES(0), .BIG_ENDIAN(1'b1)) u_ws0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .instr(bus0), .instr_fault(flt[0]),
    .prog_write(prog_write), .prog_index(prog_index), .prog_data(prog_data)
`ifdef MIPS_IROM_FETCH_COUNT_EN
    , .fetch_count(fc0), .fault_addr(fa0)
`endif
  );

  mips_instr_rom_ws #(.DEPTH(64), .BASE_ADDR(32'hBFC00000), .WAIT_STATES(2), .BIG_ENDIAN(1'b1)) u_ws2 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .instr(bus1), .instr_fault(flt[1]),
    .prog_write(prog_write), .prog_index(prog_index), .prog_data(prog_data)
`ifdef MIPS_IROM_FETCH_COUNT_EN
    , .fetch_count(fc1), .fault_addr(fa1)
`endif
  );

  mips_instr_rom_ws #(.DEPTH(64), .BASE_ADDR(32'hBFC00000), .WAIT_STATES(3), .BIG_ENDIAN(1'b1)) u_ws3 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .instr(bus2), .instr_fault(flt[2]),
    .prog_write(prog_write), .prog_index(prog_index), .prog_data(prog_data)
`ifdef MIPS_IROM_FETCH_COUNT_EN
    , .fetch_count(fc2), .fault_addr(fa2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    longint unsigned la;
    la = 64'(a);
    return (la >= BASE) && (la < BASE + 4 * DEPTH) && (la % 4 == 0);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] w, s;
    int i;
    if (!in_win(a)) return 32'h0;
    i = int'((64'(a) - BASE) / 4);
    w = mem_m[i];
    s = {<<8{w}};
    return s;
  endfunction

  function automatic bit exp_fault(input logic [31:0] a);
    return (a != 32'h0) && !in_win(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic prog(input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    prog_write = 1'b1;
    prog_index = 6'(idx);
    prog_data  = d;
    @(posedge clk); #1;
    prog_write = 1'b0;
    mem_m[idx] = d;
  endtask

  task automatic start(input int k, input logic [31:0] a);
    @(posedge clk); #1;
    addr_drv[k] = a;
    rd[k]       = 1'b1;
  endtask

  task automatic wait_served(input int k, output int n);
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (!wreq[k]) break;
      n++;
    end
  endtask

  task automatic release_rd(input int k);
    @(posedge clk); #1;
    rd[k] = 1'b0;
  endtask

  task automatic fetch(input int k, input logic [31:0] a, input string tag);
    int n;
    logic [31:0] e;
    e = exp_word(a);
    if (exp_fault(a)) flt_m[k] = 1'b1;
    start(k, a);
    wait_served(k, n);
    chk({tag, ".lat"},   32'(n), 32'(ws_of(k) + 1));
    chk({tag, ".data"},  rdata[k], e);
    chk({tag, ".fault"}, {31'b0, flt[k]}, {31'b0, flt_m[k]});
  endtask

  initial begin
    int n;
    int k;
    int r;
    logic [31:0] a;

    reset      = 1'b0;
    clk_enable = 1'b1;
    prog_write = 1'b0;
    prog_index = '0;
    prog_data  = '0;
    flt_m      = '0;
    for (int i = 0; i < 3; i++) begin
      addr_drv[i] = '0;
      rd[i]       = 1'b0;
    end

    // Load program while reset is held
    for (int i = 0; i < 64; i++) prog(i, $urandom);
    prog(3, 32'h24A5000B);
    prog(0, 32'h2484FFFF);
    prog(1, 32'h00042400);
    prog(5, 32'h12345678);

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset.rdata", rdata[i], 32'h0);
      chk("reset.wreq",  {31'b0, wreq[i]}, 32'h0);
      chk("reset.fault", {31'b0, flt[i]}, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // Two wait states, index 3
    fetch(1, B32 + 32'h0C, "ws2_idx3");
    chk("ws2_idx3.const", rdata[1], 32'h0B00A524);
    release_rd(1);

    // Back-to-back with zero wait states
    fetch(0, B32, "b2b_0");
    chk("b2b_0.const", rdata[0], 32'hFFFF8424);
    fetch(0, B32 + 32'h4, "b2b_1");
    chk("b2b_1.const", rdata[0], 32'h00240400);
    release_rd(0);

    // Halt address, misaligned fault, stickiness
    fetch(0, 32'h0, "halt");
    chk("halt.nofault", {31'b0, flt[0]}, 32'h0);
    release_rd(0);
    fetch(0, B32 + 32'h102, "misalign");
    chk("misalign.fault", {31'b0, flt[0]}, 32'h1);
    release_rd(0);
    fetch(0, B32, "sticky");
    chk("sticky.fault", {31'b0, flt[0]}, 32'h1);
    release_rd(0);

    // Window edges
    fetch(2, B32 + 32'h100, "past_end");
    chk("past_end.fault", {31'b0, flt[2]}, 32'h1);
    release_rd(2);
    fetch(2, B32 + 32'hFC, "last_word");
    release_rd(2);

    // Address change while BUSY restarts the wait
    start(2, B32);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    addr_drv[2] = B32 + 32'h4;
    wait_served(2, n);
    chk("abort.lat",  32'(n), 32'd4);
    chk("abort.data", rdata[2], 32'h00240400);
    release_rd(2);

    // Program write on the same edge as the output load
    @(posedge clk); #1;
    addr_drv[0] = B32 + 32'h14;
    rd[0]       = 1'b1;
    prog_write  = 1'b1;
    prog_index  = 6'd5;
    prog_data   = 32'h0000002A;
    @(posedge clk); #1;
    prog_write  = 1'b0;
    mem_m[5]    = 32'h0000002A;
    @(negedge clk);
    chk("wfirst.wreq",  {31'b0, wreq[0]}, 32'h0);
    chk("wfirst.data",  rdata[0], 32'h2A000000);
    release_rd(0);

    // clk_enable freeze mid-BUSY; program write during freeze must be dropped
    start(1, B32 + 32'h4);
    @(negedge clk);
    @(posedge clk); #1;
    clk_enable = 1'b0;
    prog_write = 1'b1;
    prog_index = 6'd7;
    prog_data  = ~mem_m[7];
    repeat (3) begin
      @(negedge clk);
      chk("freeze.wreq", {31'b0, wreq[1]}, 32'h1);
      @(posedge clk);
    end
    #1;
    clk_enable = 1'b1;
    prog_write = 1'b0;
    wait_served(1, n);
    chk("freeze.lat",  32'(n), 32'd2);
    chk("freeze.data", rdata[1], 32'h00240400);
    release_rd(1);
    fetch(0, B32 + 32'h1C, "freeze_nowrite");
    release_rd(0);

    // Asynchronous reset while BUSY
    start(1, B32 + 32'h0C);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("areset.rdata",  rdata[1], 32'h0);
    chk("areset.wreq",   {31'b0, wreq[1]}, 32'h0);
    chk("areset.fault0", {31'b0, flt[0]}, 32'h0);
    rd[1] = 1'b0;
    flt_m = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    fetch(1, B32 + 32'h0C, "retain");
    chk("retain.const", rdata[1], 32'h0B00A524);
    release_rd(1);

    // Randomized fetches and reprogramming
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) prog(int'($urandom_range(0, 63)), $urandom);
      k = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      if (r <= 4)      a = B32 + 4 * $urandom_range(0, 63);
      else if (r == 5) a = 32'h0;
      else if (r == 6) a = B32 + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
      else if (r == 7) a = B32 + 32'h100 + 4 * $urandom_range(0, 3);
      else if (r == 8) a = B32 - 4 * $urandom_range(1, 4);
      else             a = $urandom;
      fetch(k, a, "rand");
      release_rd(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_instr_rom_ws.md
Name: mips_instr_rom_ws

Overview:
- Parametrised, programmable instruction memory for the Harvard MIPS CPU benches; it replaces per-test hard-coded instruction decode.
- Serves word fetches from a reset-vector-based window (default 0xBFC00000), with a configurable number of wait states and a waitrequest handshake.
- Performs optional byte-lane swapping into the CPU's big-endian instruction order.
- Accepts a word-indexed program port so benches can load code before releasing reset.

Parameters:
- DEPTH, 64: number of 32-bit words in the window; power of two, at least 2.
- BASE_ADDR, 32'hBFC00000: byte address of word 0.
- WAIT_STATES, 0: extra fetch cycles, range 0..15.
- BIG_ENDIAN, 1: 1 = output bytes swapped ({d[7:0],d[15:8],d[23:16],d[31:24]}); 0 = passthrough.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clk_enable  in  1  when low, FSM, counter and program writes are frozen.
- instr_address  in  32  CPU fetch byte address.
- instr_read  in  1  fetch request; held until waitrequest is low.
- instr_readdata  out  32  fetched word, registered.
- instr_waitrequest  out  1  high while the held request is not yet served.
- instr_fault  out  1  sticky flag: an out-of-window or misaligned fetch occurred.
- prog_write  in  1  program-port write strobe.
- prog_index  in  $clog2(DEPTH)  word index to write.
- prog_data  in  32  instruction word in natural MIPS order (opcode in bits 31:26).

Behaviour:
- Reset (reset low, async):
  - instr_readdata=0, instr_waitrequest=0, instr_fault=0, state=IDLE, counter=0.
  - Memory array is NOT reset; contents persist across reset.
- FSM states: IDLE, BUSY, DONE. Transitions occur only on clk edges with clk_enable=1.
- IDLE:
  - instr_read=1: latch address and load counter=WAIT_STATES.
  - If WAIT_STATES==0, load the output register and go to DONE; otherwise go to BUSY.
- BUSY:
  - If the latched address differs from instr_address, or instr_read=0: abort, reload counter and restart (stay BUSY), or go to IDLE if instr_read=0.
  - Else if counter==1: load the output register and go to DONE.
  - Else: decrement counter.
- DONE: output valid for this one cycle; return to IDLE.
- instr_waitrequest = instr_read && state!=DONE (combinational). Fetch latency is WAIT_STATES+1 cycles from request to waitrequest low.
- Decode of the latched address:
  - In window (BASE_ADDR <= a < BASE_ADDR+4*DEPTH, a[1:0]==0): word mem[(a-BASE_ADDR)>>2], byte-swapped per BIG_ENDIAN.
  - a==0: returns 0 (NOP, the CPU halt address); no fault.
  - Any other address, or a[1:0]!=0: returns 0 and sets instr_fault=1 until reset.
- Program port:
  - prog_write with clk_enable=1 writes mem[prog_index]=prog_data on the clock edge.
  - Write-first: if the same edge loads the output from the same index, the output gets prog_data.
- Wrap: BASE_ADDR+4*DEPTH lies outside the window and faults; there is no index wrap-around.
- clk_enable low: all registers hold, including the waitrequest state.

Optional Feature:
- Macro MIPS_IROM_FETCH_COUNT_EN.
- Defined:
  - Adds output port fetch_count[31:0], reset to 0.
  - Increments on every DONE cycle and saturates at 32'hFFFFFFFF.
  - Adds an output port fault_addr[31:0] capturing the first faulting address.
- Undefined: neither port nor register exists; all other behaviour is identical.

Decomposition:
- Package mips_irom_pkg: state enum (IDLE/BUSY/DONE), IROM_DEFAULT_BASE=32'hBFC00000, MIPS_NOP=32'h0, function byteswap32.
- One sub-module, mips_irom_wait_ctr: counter load/decrement/abort logic producing the "last" pulse. The FSM, memory and decode stay in the top module.

Test Plan:
- Program index 3 = 32'h24A5000B, WAIT_STATES=2, BIG_ENDIAN=1, fetch 0xBFC0000C -> waitrequest high 3 cycles, then readdata=32'h0B00A524 with waitrequest low.
- WAIT_STATES=0, back-to-back fetches 0xBFC00000 then 0xBFC00004 (words 32'h2484FFFF, 32'h00042400) -> each served one cycle after request; swapped outputs 32'hFFFF8424 and 32'h00240400.
- Fetch 0x00000000 -> readdata=0, fault stays 0. Fetch 0xBFC00102 with DEPTH=64 -> readdata=0, fault=1, and fault remains 1 after a later valid fetch.
- Address changes mid-BUSY (WAIT_STATES=3) -> counter restarts; data for the new address arrives 4 cycles after the change.
- prog_write index 5 = 32'h0000002A on the same edge as the DONE load of index 5 -> readdata=32'h2A000000.
- reset asserted while BUSY -> outputs 0 immediately (async); memory contents are retained after reset release and the next fetch returns the earlier programmed word.
